// File: rtl/remote_dmem_responder.sv
// Target-side remote load/store responder: range-checks network requests against the
// local SPM windows, services them on the shared DMEM port (core has priority) and returns one response each.
module remote_dmem_responder #(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned dmem_size_p     = 1024,
  parameter int unsigned reg_id_width_p  = 5,
  parameter int unsigned err_cnt_width_p = 8,
  localparam int unsigned mask_width_lp      = data_width_p >> 3,
  localparam int unsigned dmem_addr_width_lp = (dmem_size_p > 1) ? $clog2(dmem_size_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic                          in_v_i,
  output logic                          in_ready_o,
  input  logic                          in_we_i,
  input  logic [15:0]                   in_addr_i,
  input  logic [data_width_p-1:0]       in_data_i,
  input  logic [mask_width_lp-1:0]      in_mask_i,
  input  logic [reg_id_width_p-1:0]     in_reg_id_i,

  input  logic                          core_dmem_v_i,

  output logic                          dmem_v_o,
  output logic                          dmem_w_o,
  output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
  output logic [data_width_p-1:0]       dmem_data_o,
  output logic [mask_width_lp-1:0]      dmem_mask_o,
  input  logic [data_width_p-1:0]       dmem_data_i,

  output logic                          returning_v_o,
  input  logic                          returning_yumi_i,
  output logic                          returning_we_o,
  output logic                          returning_err_o,
  output logic [data_width_p-1:0]       returning_data_o,
  output logic [reg_id_width_p-1:0]     returning_reg_id_o,

  input  logic                          reserve_v_i,
  input  logic [dmem_addr_width_lp-1:0] reserve_addr_i,
  output logic                          break_reserve_o,

  output logic [err_cnt_width_p-1:0]    err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                          accept_c;
  logic                          addr_local_c;
  logic [dmem_addr_width_lp-1:0] dmem_idx_c;

  logic                          resp_v_q,   resp_v_d;
  logic                          we_q,       we_d;
  logic                          err_q,      err_d;
  logic [data_width_p-1:0]       data_q,     data_d;
  logic [reg_id_width_p-1:0]     reg_id_q,   reg_id_d;
  logic                          brk_q,      brk_d;
  logic [err_cnt_width_p-1:0]    err_cnt_q,  err_cnt_d;

  // Local SPM windows: low 256 words and 0x500..0x7FF.
  assign addr_local_c = (in_addr_i <= 16'h00FF)
                      | ((in_addr_i >= 16'h0500) & (in_addr_i <= 16'h07FF));
  assign dmem_idx_c   = in_addr_i[dmem_addr_width_lp-1:0];

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_c) state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  if (returning_yumi_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accept handshake and same-cycle DMEM drive; the core always wins the port.
  always_comb begin
    in_ready_o  = (state_q == S_IDLE) & ~core_dmem_v_i;
    accept_c    = in_v_i & in_ready_o;
    dmem_v_o    = accept_c & addr_local_c;
    dmem_w_o    = dmem_v_o & in_we_i;
    dmem_addr_o = dmem_idx_c;
    dmem_data_o = in_data_i;
    dmem_mask_o = in_mask_i;
  end

  // Response payload, reservation break and error counter next state.
  always_comb begin
    resp_v_d  = (state_d == S_RESP);
    we_d      = we_q;
    err_d     = err_q;
    data_d    = data_q;
    reg_id_d  = reg_id_q;
    err_cnt_d = err_cnt_q;
    brk_d     = accept_c & addr_local_c & in_we_i & reserve_v_i
              & (reserve_addr_i == dmem_idx_c);
    if (accept_c) begin
      we_d     = in_we_i;
      err_d    = ~addr_local_c;
      reg_id_d = in_reg_id_i;
      data_d   = '0;
      if (~addr_local_c && ~(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + err_cnt_width_p'(1);
      end
    end
    // Read data arrives one cycle after the accept.
    if (state_q == S_WAIT) begin
      data_d = (~we_q & ~err_q) ? dmem_data_i : '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_v_q  <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      reg_id_q  <= '0;
      brk_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      resp_v_q  <= resp_v_d;
      we_q      <= we_d;
      err_q     <= err_d;
      data_q    <= data_d;
      reg_id_q  <= reg_id_d;
      brk_q     <= brk_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign returning_v_o      = resp_v_q;
  assign returning_we_o     = we_q;
  assign returning_err_o    = err_q;
  assign returning_data_o   = data_q;
  assign returning_reg_id_o = reg_id_q;
  assign break_reserve_o    = brk_q;
  assign err_cnt_o          = err_cnt_q;

`ifndef SYNTHESIS
  // A pending request must be held unchanged by the source until accepted.
  property p_req_hold;
    @(posedge clk_i) disable iff (reset_i)
      (in_v_i && !in_ready_o) |=> (in_v_i && $stable(in_we_i) && $stable(in_addr_i)
                                   && $stable(in_data_i) && $stable(in_mask_i)
                                   && $stable(in_reg_id_i));
  endproperty
  a_req_hold: assert property (p_req_hold) else $error("request dropped or changed before accept");
`endif

endmodule

// File: tb/tb_remote_dmem_responder.sv
// Randomized bench for remote_dmem_responder with a transaction-level memory/response model.
module tb_remote_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        in_v, in_ready, in_we;
  logic [15:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic [4:0]  in_reg_id;
  logic        core_v;
  logic        dmem_v, dmem_w;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_mask;
  logic        ret_v, ret_yumi, ret_we, ret_err;
  logic [31:0] ret_data;
  logic [4:0]  ret_reg_id;
  logic        reserve_v;
  logic [9:0]  reserve_addr;
  logic        break_reserve;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] dmem     [1024];
  logic [31:0] ref_mem  [1024];
  logic [7:0]  exp_err_cnt;

  always #5 clk = ~clk;

  remote_dmem_responder dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .in_v_i             (in_v),
    .in_ready_o         (in_ready),
    .in_we_i            (in_we),
    .in_addr_i          (in_addr),
    .in_data_i          (in_data),
    .in_mask_i          (in_mask),
    .in_reg_id_i        (in_reg_id),
    .core_dmem_v_i      (core_v),
    .dmem_v_o           (dmem_v),
    .dmem_w_o           (dmem_w),
    .dmem_addr_o        (dmem_addr),
    .dmem_data_o        (dmem_wdata),
    .dmem_mask_o        (dmem_mask),
    .dmem_data_i        (dmem_rdata),
    .returning_v_o      (ret_v),
    .returning_yumi_i   (ret_yumi),
    .returning_we_o     (ret_we),
    .returning_err_o    (ret_err),
    .returning_data_o   (ret_data),
    .returning_reg_id_o (ret_reg_id),
    .reserve_v_i        (reserve_v),
    .reserve_addr_i     (reserve_addr),
    .break_reserve_o    (break_reserve),
    .err_cnt_o          (err_cnt)
  );

  // Environment DMEM: synchronous read, byte-masked write.
  always @(posedge clk) begin
    if (dmem_v) begin
      if (dmem_w) begin
        for (int b = 0; b < 4; b++)
          if (dmem_mask[b]) dmem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end else begin
        dmem_rdata <= dmem[dmem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One full request/response transaction; entered and left at a negedge.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [4:0] rid,
                        input int core_cyc, input int yumi_dly, input logic stray_yumi);
    logic        loc;
    logic [9:0]  idx;
    logic [31:0] exp_data;
    logic        exp_brk;
    loc      = (addr <= 16'h00FF) || (addr >= 16'h0500 && addr <= 16'h07FF);
    idx      = addr[9:0];
    exp_brk  = we && loc && reserve_v && (reserve_addr == idx);
    exp_data = 32'h0;
    if (loc) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
        exp_data = ref_mem[idx];
      end
    end else if (exp_err_cnt != 8'hFF) begin
      exp_err_cnt = exp_err_cnt + 8'd1;
    end

    in_v = 1'b1; in_we = we; in_addr = addr; in_data = data; in_mask = mask; in_reg_id = rid;
    core_v = (core_cyc > 0);
    for (int i = 0; i < core_cyc; i++) begin
      #1;
      check("core_prio_ready", in_ready, 1'b0);
      check("core_prio_dmem_v", dmem_v, 1'b0);
      @(negedge clk);
    end
    core_v = 1'b0;
    #1;
    check("accept_ready", in_ready, 1'b1);
    check("accept_dmem_v", dmem_v, loc);
    if (loc) begin
      check("dmem_addr", dmem_addr, idx);
      check("dmem_w", dmem_w, we);
    end
    @(negedge clk);
    in_v = 1'b0;
    ret_yumi = stray_yumi;
    check("t1_valid", ret_v, 1'b0);
    check("t1_ready", in_ready, 1'b0);
    check("t1_break", break_reserve, exp_brk);
    check("t1_err_cnt", err_cnt, exp_err_cnt);
    @(negedge clk);
    ret_yumi = 1'b0;
    core_v = $urandom_range(0, 1) == 1;
    for (int i = 0; i <= yumi_dly; i++) begin
      check("resp_valid", ret_v, 1'b1);
      check("resp_err", ret_err, !loc);
      if (loc) check("resp_we", ret_we, we);
      check("resp_data", ret_data, exp_data);
      check("resp_reg_id", ret_reg_id, rid);
      check("resp_ready", in_ready, 1'b0);
      check("resp_dmem_v", dmem_v, 1'b0);
      check("resp_break", break_reserve, 1'b0);
      if (i < yumi_dly) @(negedge clk);
    end
    ret_yumi = 1'b1;
    @(negedge clk);
    ret_yumi = 1'b0;
    core_v   = 1'b0;
    #1;
    check("post_valid", ret_v, 1'b0);
    check("post_ready", in_ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] a;
    logic        w;
    for (int i = 0; i < 1024; i++) begin
      dmem[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    dmem_rdata   = 32'h0;
    exp_err_cnt  = 8'h0;
    reset_i = 1'b1; in_v = 1'b0; in_we = 1'b0; in_addr = 16'h0; in_data = 32'h0;
    in_mask = 4'h0; in_reg_id = 5'h0; core_v = 1'b0; ret_yumi = 1'b0;
    reserve_v = 1'b0; reserve_addr = 10'h0;
    #1;
    check("rst_valid", ret_v, 1'b0);
    check("rst_we", ret_we, 1'b0);
    check("rst_err", ret_err, 1'b0);
    check("rst_data", ret_data, 32'h0);
    check("rst_reg_id", ret_reg_id, 5'h0);
    check("rst_break", break_reserve, 1'b0);
    check("rst_err_cnt", err_cnt, 8'h0);
    @(negedge clk); @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("rst_ready", in_ready, 1'b1);
    @(negedge clk);

    // Store then load.
    do_req(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 5'd3, 0, 0, 1'b0);
    do_req(1'b0, 16'h0010, 32'h0, 4'h0, 5'd7, 0, 0, 1'b0);
    // High window and error address.
    do_req(1'b0, 16'h0500, 32'h0, 4'h0, 5'd1, 0, 0, 1'b0);
    do_req(1'b0, 16'h0100, 32'h0, 4'h0, 5'd2, 0, 0, 1'b0);
    // Core priority, backpressure, stray yumi in WAIT.
    do_req(1'b1, 16'h07FF, 32'h12345678, 4'h5, 5'd4, 3, 5, 1'b1);
    do_req(1'b0, 16'h07FF, 32'h0, 4'h0, 5'd5, 0, 0, 1'b0);
    do_req(1'b0, 16'h04FF, 32'h0, 4'h0, 5'd6, 0, 0, 1'b0);
    do_req(1'b0, 16'h0800, 32'h0, 4'h0, 5'd6, 0, 0, 1'b0);
    // Reservation.
    reserve_v = 1'b1; reserve_addr = 10'h020;
    do_req(1'b1, 16'h0020, 32'hA5A5A5A5, 4'hF, 5'd8, 0, 0, 1'b0);
    do_req(1'b0, 16'h0020, 32'h0, 4'h0, 5'd9, 0, 0, 1'b0);
    do_req(1'b1, 16'h0021, 32'h5A5A5A5A, 4'hF, 5'd10, 0, 0, 1'b0);
    reserve_v = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 15));
        1:       a = 16'($urandom_range(16'h0500, 16'h0510));
        2:       a = 16'($urandom_range(16'h0100, 16'h04FF));
        default: a = 16'($urandom_range(16'h0800, 16'hFFFF));
      endcase
      w = $urandom_range(0, 1) == 1;
      reserve_v    = $urandom_range(0, 1) == 1;
      reserve_addr = ($urandom_range(0, 1) == 1) ? a[9:0] : 10'($urandom);
      do_req(w, a, $urandom, 4'($urandom), 5'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end
    reserve_v = 1'b0;

    // Asynchronous reset while a response is waiting.
    in_v = 1'b1; in_we = 1'b0; in_addr = 16'h0200; in_reg_id = 5'd11;
    @(negedge clk);
    in_v = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", ret_v, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_valid", ret_v, 1'b0);
    check("async_rst_err", ret_err, 1'b0);
    check("async_rst_reg_id", ret_reg_id, 5'h0);
    check("async_rst_err_cnt", err_cnt, 8'h0);
    exp_err_cnt = 8'h0;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);
    @(negedge clk);

    // Error counter saturation.
    for (int n = 0; n < 300; n++)
      do_req($urandom_range(0, 1) == 1, 16'($urandom_range(16'h0800, 16'hFFFF)), $urandom,
             4'hF, 5'($urandom), 0, 0, 1'b0);
    check("err_cnt_sat", err_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/remote_dmem_responder.md
Name: remote_dmem_responder

Overview:
Target-side counterpart of the vanilla core's load/store unit. It accepts remote load/store requests arriving from the network endpoint and checks that each address falls in the tile's local SPM windows. In-range requests are serviced against the shared DMEM port, which the core always wins. The block then returns one response per request over a valid/yumi handshake, and signals when a remote store breaks the core's LR reservation.

Parameters:
data_width_p, 32, data word width (mask width = data_width_p>>3)
dmem_size_p, 1024, DMEM depth in words; localparam dmem_addr_width_lp = `BSG_SAFE_CLOG2(dmem_size_p)
reg_id_width_p, 5, width of returned register id
err_cnt_width_p, 8, width of saturating error counter

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
in_v_i  in  1  incoming request valid
in_ready_o  out  1  request accepted when in_v_i & in_ready_o
in_we_i  in  1  1=store, 0=load
in_addr_i  in  16  tile-local word address (EPA)
in_data_i  in  data_width_p  store data
in_mask_i  in  data_width_p>>3  store byte mask
in_reg_id_i  in  reg_id_width_p  requester reg id, echoed back
core_dmem_v_i  in  1  core LSU uses DMEM this cycle (priority)
dmem_v_o  out  1  DMEM access enable
dmem_w_o  out  1  DMEM write
dmem_addr_o  out  dmem_addr_width_lp  DMEM word index
dmem_data_o  out  data_width_p  DMEM write data
dmem_mask_o  out  data_width_p>>3  DMEM write mask
dmem_data_i  in  data_width_p  DMEM read data, valid 1 cycle after read
returning_v_o  out  1  response valid
returning_yumi_i  in  1  response consumed
returning_we_o  out  1  response is a store ack
returning_err_o  out  1  address outside local SPM
returning_data_o  out  data_width_p  load data (0 for stores and errors)
returning_reg_id_o  out  reg_id_width_p  echoed reg id
reserve_v_i  in  1  core LR reservation active
reserve_addr_i  in  dmem_addr_width_lp  reserved DMEM word index
break_reserve_o  out  1  one-cycle pulse: remote store hit the reserved word
err_cnt_o  out  err_cnt_width_p  saturating count of error responses

Behaviour:
- In-range (local) address: in_addr_i in [0x0000:0x00FF] or [0x0500:0x07FF]. Any other address is an error.
- DMEM index: in_addr_i[dmem_addr_width_lp-1:0]. With default depth, 0x500..0x7FF maps to indices 0x100..0x3FF.
- State machine has three states: IDLE, WAIT, RESP. Reset value is IDLE.
- in_ready_o = (state==IDLE) & ~core_dmem_v_i. It is purely combinational; the block never buffers a request it has not accepted.
- Accept cycle T, in-range request:
  - dmem_v_o=1 in the same cycle; dmem_w_o=in_we_i; addr, data and mask driven straight from the inputs.
  - Go to WAIT. we and reg_id are latched.
- Accept cycle T, error request:
  - dmem_v_o stays 0.
  - Go to WAIT with err latched.
  - err_cnt_o increments at the T+1 edge and saturates at all-ones.
- dmem_v_o=0 in every cycle that is not an in-range accept. The block must never assert it while core_dmem_v_i=1.
- WAIT (T+1):
  - Capture returning_data_o = dmem_data_i for an in-range load, otherwise 0.
  - Go to RESP.
- RESP (from T+2):
  - returning_v_o=1 with all response fields held stable.
  - On returning_yumi_i → IDLE. The earliest next accept is the cycle after yumi.
  - Peak throughput is one request per 3 cycles.
- returning_yumi_i while not in RESP is ignored.
- break_reserve_o is a registered pulse at T+1. Condition: an in-range store was accepted at T, reserve_v_i=1, and reserve_addr_i equals the DMEM index. Loads and error stores never pulse it.
- Reset values (all asynchronous): state=IDLE, returning_v_o=0, returning_we_o=0, returning_err_o=0, returning_data_o=0, returning_reg_id_o=0, break_reserve_o=0, err_cnt_o=0.
- Reset during WAIT/RESP: any in-flight response is dropped. A store already written to DMEM stays written.
- Simultaneous events:
  - in_v_i and core_dmem_v_i in the same cycle: core wins and in_ready_o=0; the request stays pending at the source.
  - core_dmem_v_i in WAIT/RESP has no effect.
- Assertion (sim only): in_v_i must stay asserted with stable fields until accepted.

Test Plan:
- Remote store then load: store addr 0x0010, data 0xDEADBEEF, mask 4'hF, then load 0x0010 reg_id 7 → store ack with returning_we_o=1 and data 0; load response data 0xDEADBEEF, reg_id 7, both at T+2.
- High window mapping: load addr 0x0500 → dmem_addr_o=0x100, err=0; load addr 0x0100 → no DMEM access, returning_err_o=1, data 0, err_cnt_o increments 0→1.
- Core priority: in_v_i held with core_dmem_v_i=1 for 3 cycles → in_ready_o=0 and dmem_v_o=0 for all 3; accepted in the first cycle core_dmem_v_i drops.
- Backpressure: hold returning_yumi_i=0 for 5 cycles in RESP → fields stable, in_ready_o=0; yumi → IDLE, next request accepted the following cycle.
- Reservation: reserve_v_i=1, reserve_addr_i=0x020; remote store to 0x0020 → break_reserve_o single pulse at T+1; load to 0x0020 or store to 0x0021 → no pulse.
- Async reset in RESP plus counter saturation: reset → returning_v_o=0 immediately (no clock edge needed); 300 error requests → err_cnt_o holds at 255.
